// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the 8-bit softcore.
// It owns the fetch handshake, the PC and the compare flags, and it drives the ALU strobes.
`ifndef ISA_INSN_COUNT
`define ISA_ADD        0
`define ISA_ADDI       1
`define ISA_SH         2
`define ISA_SHI        3
`define ISA_NOT        4
`define ISA_AND        5
`define ISA_OR         6
`define ISA_XOR        7
`define ISA_INSN_COUNT 8
`endif

`ifndef ALU_FLAG_EQ
`define ALU_FLAG_EQ 0
`define ALU_FLAG_GT 1
`endif

module alu_ctrl_fsm #(
    parameter int BIT_COUNT  = 8,
    parameter int PC_WIDTH   = 8,
    parameter int INSN_COUNT = `ISA_INSN_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [BIT_COUNT-1:0]  imem_rdata,
    output logic                  rf_rd_en,
    output logic [3:0]            rf_rd_addr,
    output logic                  bus_imm_sel,
    output logic [INSN_COUNT-1:0] alu_insn_en,
    input  logic [1:0]            alu_flags,
    output logic                  acc_we,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted,
    output logic                  illegal
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SH   = 4'h3;
    localparam logic [3:0] OP_SHI  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BGT  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [BIT_COUNT-1:0] ir_q, ir_d;
    logic                 flag_eq_q, flag_eq_d;
    logic                 flag_gt_q, flag_gt_d;
    logic                 illegal_q, illegal_d;

    logic [3:0] opcode;
    logic [3:0] imm;

    assign opcode = ir_q[7:4];
    assign imm    = ir_q[3:0];

    function automatic logic is_reg_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SH, OP_AND, OP_OR, OP_XOR, OP_CMP};
    endfunction

    function automatic logic is_imm_op(input logic [3:0] op);
        return op inside {OP_ADDI, OP_SHI};
    endfunction

    function automatic logic writes_acc(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    // CMP reuses the XOR datapath; only the flags are kept from it.
    function automatic logic [INSN_COUNT-1:0] alu_enable(input logic [3:0] op);
        logic [INSN_COUNT-1:0] en;
        en = '0;
        case (op)
            OP_ADD:         en[`ISA_ADD]  = 1'b1;
            OP_ADDI:        en[`ISA_ADDI] = 1'b1;
            OP_SH:          en[`ISA_SH]   = 1'b1;
            OP_SHI:         en[`ISA_SHI]  = 1'b1;
            OP_NOT:         en[`ISA_NOT]  = 1'b1;
            OP_AND:         en[`ISA_AND]  = 1'b1;
            OP_OR:          en[`ISA_OR]   = 1'b1;
            OP_XOR, OP_CMP: en[`ISA_XOR]  = 1'b1;
            default:        en = '0;
        endcase
        return en;
    endfunction

    function automatic logic [PC_WIDTH-1:0] sext_imm(input logic [3:0] v);
        return {{(PC_WIDTH-4){v[3]}}, v};
    endfunction

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flag_eq_d = flag_eq_q;
        flag_gt_d = flag_gt_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_ONE;
                case (opcode)
                    OP_CMP: begin
                        flag_eq_d = alu_flags[`ALU_FLAG_EQ];
                        flag_gt_d = alu_flags[`ALU_FLAG_GT];
                    end
                    OP_BEQ: if (flag_eq_q) pc_d = pc_q + sext_imm(imm);
                    OP_BGT: if (flag_gt_q) pc_d = pc_q + sext_imm(imm);
                    OP_JMP: pc_d = pc_q + sext_imm(imm);
                    4'hE, 4'hF: illegal_d = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Control state: reset wins over a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            flag_eq_q <= 1'b0;
            flag_gt_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flag_eq_q <= flag_eq_d;
            flag_gt_q <= flag_gt_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        ir_q <= ir_d;
    end

    // Moore outputs; rst forces every strobe low during the reset cycle itself.
    always_comb begin
        imem_req    = 1'b0;
        rf_rd_en    = 1'b0;
        bus_imm_sel = 1'b0;
        alu_insn_en = '0;
        acc_we      = 1'b0;
        if (!rst) begin
            imem_req    = (state_q == S_FETCH);
            rf_rd_en    = (state_q == S_DECODE) && is_reg_op(opcode);
            bus_imm_sel = ((state_q == S_DECODE) || (state_q == S_EXEC)) && is_imm_op(opcode);
            if (state_q == S_EXEC) begin
                alu_insn_en = alu_enable(opcode);
                acc_we      = writes_acc(opcode);
            end
        end
    end

    assign imem_addr  = pc_q;
    assign rf_rd_addr = imm;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);
    assign illegal    = illegal_q;

endmodule
